multi_clip_controller: RTL and testbench

MULTI_CLIP_CONTROLLER -- requirements
Module: multi_clip_controller

---
 rtl/multi_clip_controller.sv | 198 +++++++++++++++++++
 tb/tb_multi_clip_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multi_clip_controller.sv
// Multi-slot audio clip recorder/player driving a single-port sample memory.
// Optional build macro CLIP_LOOP_EN: playback loops the clip until stop_i.
module multi_clip_controller #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_CLIPS   = 4,
  parameter int CLIP_DEPTH  = 32768,
  localparam int CB = $clog2(NUM_CLIPS),
  localparam int AW = $clog2(CLIP_DEPTH)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   play_i,
  input  logic                   record_i,
  input  logic                   stop_i,
  input  logic [CB-1:0]          clip_select_i,
  input  logic                   sample_tick_i,
  input  logic [WORD_LENGTH-1:0] mic_data_i,
  input  logic [WORD_LENGTH-1:0] mem_rdata_i,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [CB+AW-1:0]       mem_addr_o,
  output logic [WORD_LENGTH-1:0] mem_wdata_o,
  output logic [WORD_LENGTH-1:0] spk_data_o,
  output logic                   spk_valid_o,
  output logic                   recording_o,
  output logic                   playing_o,
  output logic [CB-1:0]          active_clip_o,
  output logic [NUM_CLIPS-1:0]   clip_valid_o,
  output logic                   done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

`ifdef CLIP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic [1:0]             state_q, state_d;
  logic [AW:0]            ptr_q, ptr_d;
  logic [CB-1:0]          clip_q, clip_d;
  logic [AW:0]            len_q [NUM_CLIPS];
  logic [AW:0]            len_d [NUM_CLIPS];
  logic [NUM_CLIPS-1:0]   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   last_pend_q, last_pend_d;
  logic                   spk_valid_q, spk_valid_d;
  logic [WORD_LENGTH-1:0] spk_data_q, spk_data_d;
  logic                   play_prev_q, rec_prev_q, armed_q;
  logic                   play_edge_s, rec_edge_s, mem_en_s, mem_we_s;
  logic [AW:0]            cur_len_s;

  // armed_q blocks the first post-reset cycle so a level held through reset never counts as an edge
  assign play_edge_s = armed_q & play_i & ~play_prev_q;
  assign rec_edge_s  = armed_q & record_i & ~rec_prev_q;
  assign cur_len_s   = len_q[clip_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clip_d      = clip_q;
    len_d       = len_q;
    valid_d     = valid_q;
    rd_pend_d   = 1'b0;
    last_pend_d = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    spk_valid_d = rd_pend_q;
    done_d      = rd_pend_q & last_pend_q;
    if (rd_pend_q) begin
      spk_data_d = mem_rdata_i;
    end else if (state_q == S_IDLE) begin
      spk_data_d = '0;
    end else begin
      spk_data_d = spk_data_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rec_edge_s) begin
          state_d = S_REC;
          clip_d  = clip_select_i;
          ptr_d   = '0;
        end else if (play_edge_s && valid_q[clip_select_i]) begin
          state_d = S_PLAY;
          clip_d  = clip_select_i;
          ptr_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REC: begin
        if (stop_i) begin
          len_d[clip_q]   = ptr_q;
          valid_d[clip_q] = (ptr_q != '0);
          done_d          = 1'b1;
          state_d         = S_IDLE;
          ptr_d           = '0;
        end else if (sample_tick_i) begin
          mem_en_s = 1'b1;
          mem_we_s = 1'b1;
          if (ptr_q == (AW+1)'(CLIP_DEPTH - 1)) begin
            len_d[clip_q]   = (AW+1)'(CLIP_DEPTH);
            valid_d[clip_q] = 1'b1;
            done_d          = 1'b1;
            state_d         = S_IDLE;
            ptr_d           = '0;
          end else begin
            ptr_d = ptr_q + (AW+1)'(1);
          end
        end else begin
          state_d = S_REC;
        end
      end
      S_PLAY: begin
        if (stop_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          // Without looping, ptr parks at the length after the last read so later ticks issue nothing
          if (sample_tick_i && (LOOP || (ptr_q != cur_len_s))) begin
            mem_en_s  = 1'b1;
            rd_pend_d = 1'b1;
            if (ptr_q == cur_len_s - (AW+1)'(1)) begin
              last_pend_d = 1'b1;
              ptr_d       = LOOP ? '0 : ptr_q + (AW+1)'(1);
            end else begin
              ptr_d = ptr_q + (AW+1)'(1);
            end
          end else begin
            ptr_d = ptr_q;
          end
          if (!LOOP && last_pend_q) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else begin
            state_d = S_PLAY;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      clip_q      <= '0;
      valid_q     <= '0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_data_q  <= '0;
      play_prev_q <= 1'b0;
      rec_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clip_q      <= clip_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_pend_d;
      last_pend_q <= last_pend_d;
      spk_valid_q <= spk_valid_d;
      spk_data_q  <= spk_data_d;
      play_prev_q <= play_i;
      rec_prev_q  <= record_i;
      armed_q     <= 1'b1;
    end
  end

  // Memory strobes are combinational so the access lands in the tick cycle itself
  assign mem_en_o      = mem_en_s & ~reset_i;
  assign mem_we_o      = mem_we_s & ~reset_i;
  assign mem_addr_o    = mem_en_o ? {clip_q, ptr_q[AW-1:0]} : '0;
  assign mem_wdata_o   = (mem_en_o && mem_we_o) ? mic_data_i : '0;
  assign spk_data_o    = spk_data_q;
  assign spk_valid_o   = spk_valid_q;
  assign recording_o   = (state_q == S_REC);
  assign playing_o     = (state_q == S_PLAY);
  assign active_clip_o = clip_q;
  assign clip_valid_o  = valid_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_multi_clip_controller.sv
// Directed bench for multi_clip_controller (4 clips x 8 samples x 16 bits) with a behavioural memory.
module tb_multi_clip_controller;
  logic clk = 1'b0;
  logic reset_i = 1'b1, play_i = 1'b0, record_i = 1'b0, stop_i = 1'b0, tick = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] mic = 16'd0, rdata = 16'd0;
  logic        mem_en, mem_we, spk_valid, recording, playing, done;
  logic [4:0]  addr;
  logic [15:0] wdata, spk_data;
  logic [1:0]  active;
  logic [3:0]  cvalid;
  logic [15:0] mem [32];
  int wr_cnt = 0;
  int wr_base;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_clip_controller #(.WORD_LENGTH(16), .NUM_CLIPS(4), .CLIP_DEPTH(8)) dut (
    .clock_i(clk), .reset_i(reset_i), .play_i(play_i), .record_i(record_i), .stop_i(stop_i),
    .clip_select_i(sel), .sample_tick_i(tick), .mic_data_i(mic), .mem_rdata_i(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .spk_data_o(spk_data), .spk_valid_o(spk_valid), .recording_o(recording), .playing_o(playing),
    .active_clip_o(active), .clip_valid_o(cvalid), .done_o(done));

  // Single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[addr] <= wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_en && !mem_we) rdata <= mem[addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with both commands held high; release must not trigger them
    record_i = 1'b1; play_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1 chk("rst_rec", 32'(recording), 32'd0);
    chk("rst_cvalid", 32'(cvalid), 32'd0);
    chk("rst_spk", 32'(spk_data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("held_lvl", 32'({recording, playing}), 32'd0);
    end
    @(negedge clk); record_i = 1'b0; play_i = 1'b0;

    // Record clip 2 with three samples, then stop with a coincident tick
    @(negedge clk); sel = 2'd2; record_i = 1'b1;
    @(negedge clk); record_i = 1'b0; sel = 2'd0;
    #1 chk("rec2_state", 32'(recording), 32'd1);
    chk("rec2_active", 32'(active), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); tick = 1'b1; mic = 16'(i);
      #1 chk("rec2_wr", 32'({mem_en, mem_we, addr}), 32'({2'b11, 5'(16 + i - 1)}));
      chk("rec2_wdata", 32'(wdata), 32'(i));
      @(negedge clk); tick = 1'b0;
      #1 chk("rec2_idle_en", 32'(mem_en), 32'd0);
    end
    @(negedge clk); stop_i = 1'b1; tick = 1'b1; mic = 16'h00FF;
    #1 chk("rec2_stop_nowr", 32'(mem_en), 32'd0);
    @(negedge clk); stop_i = 1'b0; tick = 1'b0;
    #1 chk("rec2_done", 32'(done), 32'd1);
    chk("rec2_cvalid", 32'(cvalid), 32'h4);
    chk("rec2_idle", 32'(recording), 32'd0);
    @(negedge clk); #1 chk("rec2_done_pulse", 32'(done), 32'd0);

    // Play clip 2: tick-to-valid latency of two cycles, done with the last sample
    @(negedge clk); sel = 2'd2; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0; sel = 2'd3;
    #1 chk("play2_state", 32'(playing), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); tick = 1'b1;
      #1 chk("play2_rd", 32'({mem_en, mem_we, addr}), 32'({2'b10, 5'(16 + i - 1)}));
      if (i > 1) chk("play2_hold", 32'(spk_data), 32'(i - 1));
      @(negedge clk); tick = 1'b0;
      #1 chk("play2_lat", 32'(spk_valid), 32'd0);
      @(negedge clk);
      #1 chk("play2_valid", 32'(spk_valid), 32'd1);
      chk("play2_data", 32'(spk_data), 32'(i));
      chk("play2_done", 32'(done), 32'(i == 3));
    end
    @(negedge clk);
    #1 chk("play2_end", 32'({playing, done, spk_valid}), 32'd0);
    chk("play2_clear", 32'(spk_data), 32'd0);

    // Stop during playback with a read in flight
    @(negedge clk); sel = 2'd2; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0;
    #1 chk("stopplay_out", 32'({done, spk_valid, playing}), 32'b110);
    chk("stopplay_data", 32'(spk_data), 32'd1);

    // Record clip 0 for ten ticks: only eight land, auto-stop after the eighth
    @(negedge clk); sel = 2'd0; record_i = 1'b1;
    @(negedge clk); record_i = 1'b0; wr_base = wr_cnt;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); tick = 1'b1; mic = 16'(16'h00A0 + i);
      #1 chk("rec0_en", 32'(mem_en), 32'(i <= 8));
      if (i <= 8) chk("rec0_addr", 32'(addr), 32'(i - 1));
      @(negedge clk); tick = 1'b0;
      #1 if (i == 8) chk("rec0_auto", 32'({done, recording}), 32'b10);
    end
    chk("rec0_count", 32'(wr_cnt - wr_base), 32'd8);
    chk("rec0_cvalid", 32'(cvalid), 32'h5);
    chk("rec0_mem7", 32'(mem[7]), 32'h00A8);

    // Simultaneous edges on clip 1: record wins; edges during REC ignored; stop at ptr 0
    @(negedge clk); sel = 2'd1; play_i = 1'b1; record_i = 1'b1;
    @(negedge clk); play_i = 1'b0; record_i = 1'b0;
    #1 chk("both_rec", 32'({recording, playing, active}), 32'b1001);
    @(negedge clk); sel = 2'd3; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0;
    #1 chk("rec_ignore", 32'({recording, playing, active}), 32'b1001);
    @(negedge clk); stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0;
    #1 chk("empty_stop", 32'({done, cvalid}), 32'b10101);
    @(negedge clk); sel = 2'd3; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0;
    #1 chk("empty_play", 32'({playing, done}), 32'd0);
    @(negedge clk); #1 chk("empty_play2", 32'({playing, done}), 32'd0);

`ifdef CLIP_LOOP_EN
    // Looping playback of a three-sample clip
    @(negedge clk); sel = 2'd3; record_i = 1'b1;
    @(negedge clk); record_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); tick = 1'b1; mic = 16'(i);
      @(negedge clk); tick = 1'b0;
    end
    @(negedge clk); stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      #1 chk("loop_data", 32'({spk_valid, spk_data}), 32'({1'b1, 16'(((k - 1) % 3) + 1)}));
      chk("loop_done", 32'(done), 32'((k == 3) || (k == 6)));
    end
    @(negedge clk); stop_i = 1'b1;
    @(negedge clk); stop_i = 1'b0;
    #1 chk("loop_stop", 32'({playing, done}), 32'b01);
`endif

    // Reset mid-record at ptr 4 clears everything
    @(negedge clk); sel = 2'd1; record_i = 1'b1;
    @(negedge clk); record_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); tick = 1'b1; mic = 16'(16'h0050 + i);
      @(negedge clk); tick = 1'b0;
    end
    @(negedge clk); reset_i = 1'b1; tick = 1'b1;
    #1 chk("rst_mid_en", 32'(mem_en), 32'd0);
    @(negedge clk); reset_i = 1'b0; tick = 1'b0;
    #1 chk("rst_mid_state", 32'({recording, playing, done, spk_valid}), 32'd0);
    chk("rst_mid_cvalid", 32'({cvalid, active}), 32'd0);
    @(negedge clk);
    @(negedge clk); sel = 2'd1; play_i = 1'b1;
    @(negedge clk); play_i = 1'b0;
    #1 chk("rst_play_ign", 32'({playing, done}), 32'd0);
    @(negedge clk); #1 chk("rst_play_ign2", 32'({playing, done, mem_en}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
